// File: rtl/pd_seq_pkg.sv
// Shared definitions for the PD_M1 power-domain sequencer.
// Holds the sequencer state enum, the default timing constants and a helper
// that sizes the shared timeout/hold counter.
package pd_seq_pkg;

    typedef enum logic [2:0] {
        StOff,
        StPwrUp,
        StRstRel,
        StDeiso,
        StOn,
        StIso,
        StPwrDn
    } pd_state_e;

    localparam int unsigned IsoSetupCyclesDef = 4;
    localparam int unsigned RstHoldCyclesDef  = 8;
    localparam int unsigned AckTimeoutDef     = 64;

    // Counter must hold the largest of the three cycle counts.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer, reset to 0.
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset
//   d_i    - asynchronous input
//   q_o    - synchronized output (2 cycles of latency)
module sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic s1_q, s2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/pd_m1_seq.sv
// PD_M1 power-domain sequencer (always-on domain).
// Sequences isolation, domain reset and power-switch enable for every PD_M1
// power-up and power-down so downstream domains never see PD_M1 outputs while
// it is unpowered or held in reset.
// Ports:
//   ck         - always-on clock
//   arst       - asynchronous active-low reset
//   pdReq      - level request, 1 = PD_M1 on
//   busyM1     - PD_M1 activity, blocks power-down while high (sampled in ON only)
//   pwrAck     - power-switch ack, asynchronous to ck
//   errClr     - clears pdErr
//   pwrEn      - power-switch enable
//   domainRstN - PD_M1 reset, active-low
//   isolateM1  - isolation enable toward PD_M2/PD_M3
//   pdAck      - high only while ON
//   pdErr      - sticky ack-timeout flag
module pd_m1_seq
    import pd_seq_pkg::*;
#(
    parameter int unsigned ISO_SETUP_CYCLES = IsoSetupCyclesDef,
    parameter int unsigned RST_HOLD_CYCLES  = RstHoldCyclesDef,
    parameter int unsigned ACK_TIMEOUT      = AckTimeoutDef
) (
    input  logic ck,
    input  logic arst,
    input  logic pdReq,
    input  logic busyM1,
    input  logic pwrAck,
    input  logic errClr,
    output logic pwrEn,
    output logic domainRstN,
    output logic isolateM1,
    output logic pdAck,
    output logic pdErr
);

    localparam int unsigned CntW = cnt_width(ISO_SETUP_CYCLES, RST_HOLD_CYCLES, ACK_TIMEOUT);

    localparam logic [CntW-1:0] CntSat     = CntW'(ACK_TIMEOUT);
    localparam logic [CntW-1:0] CntTimeout = CntW'(ACK_TIMEOUT - 1);
    localparam logic [CntW-1:0] CntIsoLast = CntW'(ISO_SETUP_CYCLES - 1);
    localparam logic [CntW-1:0] CntRstLast = CntW'(RST_HOLD_CYCLES - 1);

    pd_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ack_s;
    logic            timeout;

    logic pwr_en_q, pwr_en_d;
    logic rst_n_q, rst_n_d;
    logic iso_q, iso_d;
    logic pd_ack_q, pd_ack_d;
    logic pd_err_q, pd_err_d;

    sync2 u_ack_sync (
        .clk_i  (ck),
        .rst_ni (arst),
        .d_i    (pwrAck),
        .q_o    (ack_s)
    );

    // State register and cycle counter.
    always_ff @(posedge ck or negedge arst) begin
        if (!arst) begin
            state_q <= StOff;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state. cnt_q equals the number of cycles already spent in state_q.
    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        unique case (state_q)
            StOff: begin
                if (pdReq) state_d = StPwrUp;
            end
            StPwrUp: begin
                if (ack_s) begin
                    state_d = StRstRel;
                end else if (cnt_q == CntTimeout) begin
                    state_d = StRstRel;
                    timeout = 1'b1;
                end
            end
            StRstRel: begin
                if (cnt_q == CntRstLast) state_d = StDeiso;
            end
            StDeiso: begin
                state_d = StOn;
            end
            StOn: begin
                if (!pdReq && !busyM1) state_d = StIso;
            end
            StIso: begin
                if (cnt_q == CntIsoLast) state_d = StPwrDn;
            end
            StPwrDn: begin
                if (!ack_s) begin
                    state_d = StOff;
                end else if (cnt_q == CntTimeout) begin
                    state_d = StOff;
                    timeout = 1'b1;
                end
            end
            default: state_d = StOff;
        endcase

        // Cleared on every state entry, saturating otherwise.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntSat) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_comb begin
        pwr_en_d = 1'b1;
        rst_n_d  = 1'b0;
        iso_d    = 1'b1;
        pd_ack_d = 1'b0;
        unique case (state_d)
            StOff: pwr_en_d = 1'b0;
            StPwrUp, StRstRel: ;
            StDeiso: rst_n_d = 1'b1;
            StOn: begin
                rst_n_d  = 1'b1;
                iso_d    = 1'b0;
                pd_ack_d = 1'b1;
            end
            StIso: rst_n_d = 1'b1;
            // Switch stays on for the cycle in which reset goes low, so reset
            // is always applied to a powered domain.
            StPwrDn: pwr_en_d = (state_q == StIso);
            default: pwr_en_d = 1'b0;
        endcase
        // Set wins over clear.
        pd_err_d = timeout | (pd_err_q & ~errClr);
    end

    always_ff @(posedge ck or negedge arst) begin
        if (!arst) begin
            pwr_en_q <= 1'b0;
            rst_n_q  <= 1'b0;
            iso_q    <= 1'b1;
            pd_ack_q <= 1'b0;
            pd_err_q <= 1'b0;
        end else begin
            pwr_en_q <= pwr_en_d;
            rst_n_q  <= rst_n_d;
            iso_q    <= iso_d;
            pd_ack_q <= pd_ack_d;
            pd_err_q <= pd_err_d;
        end
    end

    assign pwrEn      = pwr_en_q;
    assign domainRstN = rst_n_q;
    assign isolateM1  = iso_q;
    assign pdAck      = pd_ack_q;
    assign pdErr      = pd_err_q;

endmodule

// File: tb/tb_pd_m1_seq.sv
// Self-checking bench for pd_m1_seq: directed scenarios with literal
// expectations plus a randomized run against a behavioural phase model.
module tb_pd_m1_seq;

    localparam int ISO_N  = 4;
    localparam int HOLD_N = 8;
    localparam int TO_N   = 64;

    // Model phases.
    localparam int PhOff   = 0;
    localparam int PhUp    = 1;
    localparam int PhHold  = 2;
    localparam int PhDeiso = 3;
    localparam int PhOn    = 4;
    localparam int PhIso   = 5;
    localparam int PhDn    = 6;

    logic ck = 1'b0;
    logic arst = 1'b0;
    logic pdReq = 1'b0;
    logic busyM1 = 1'b0;
    logic pwrAck = 1'b0;
    logic errClr = 1'b0;
    logic pwrEn, domainRstN, isolateM1, pdAck, pdErr;

    always #5 ck = ~ck;

    pd_m1_seq #(
        .ISO_SETUP_CYCLES (ISO_N),
        .RST_HOLD_CYCLES  (HOLD_N),
        .ACK_TIMEOUT      (TO_N)
    ) dut (
        .ck         (ck),
        .arst       (arst),
        .pdReq      (pdReq),
        .busyM1     (busyM1),
        .pwrAck     (pwrAck),
        .errClr     (errClr),
        .pwrEn      (pwrEn),
        .domainRstN (domainRstN),
        .isolateM1  (isolateM1),
        .pdAck      (pdAck),
        .pdErr      (pdErr)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_ph  = PhOff;
    int m_t   = 0;   // cycles spent in current phase
    bit m_err = 1'b0;
    bit m_s1  = 1'b0;
    bit m_s2  = 1'b0;

    always @(posedge ck or negedge arst) begin : model
        int  nph;
        bit  to;
        if (!arst) begin
            m_ph  <= PhOff;
            m_t   <= 0;
            m_err <= 1'b0;
            m_s1  <= 1'b0;
            m_s2  <= 1'b0;
        end else begin
            nph = m_ph;
            to  = 1'b0;
            case (m_ph)
                PhOff:   if (pdReq) nph = PhUp;
                PhUp:    if (m_s2) nph = PhHold;
                         else if (m_t + 1 >= TO_N) begin nph = PhHold; to = 1'b1; end
                PhHold:  if (m_t + 1 >= HOLD_N) nph = PhDeiso;
                PhDeiso: nph = PhOn;
                PhOn:    if (!pdReq && !busyM1) nph = PhIso;
                PhIso:   if (m_t + 1 >= ISO_N) nph = PhDn;
                PhDn:    if (!m_s2) nph = PhOff;
                         else if (m_t + 1 >= TO_N) begin nph = PhOff; to = 1'b1; end
                default: nph = PhOff;
            endcase
            m_err <= to ? 1'b1 : (errClr ? 1'b0 : m_err);
            m_t   <= (nph != m_ph) ? 0 : m_t + 1;
            m_ph  <= nph;
            m_s1  <= pwrAck;
            m_s2  <= m_s1;
        end
    end

    // Per-cycle compare against the model, plus ordering invariants.
    always @(negedge ck) begin : compare
        int e_pwr, e_rst, e_iso, e_ack;
        if (arst) begin
            e_pwr = ((m_ph >= PhUp && m_ph <= PhIso) || (m_ph == PhDn && m_t == 0)) ? 1 : 0;
            e_rst = (m_ph == PhDeiso || m_ph == PhOn || m_ph == PhIso) ? 1 : 0;
            e_iso = (m_ph != PhOn) ? 1 : 0;
            e_ack = (m_ph == PhOn) ? 1 : 0;
            check("model_pwrEn", int'(pwrEn), e_pwr);
            check("model_domainRstN", int'(domainRstN), e_rst);
            check("model_isolateM1", int'(isolateM1), e_iso);
            check("model_pdAck", int'(pdAck), e_ack);
            check("model_pdErr", int'(pdErr), int'(m_err));
            check("inv_iso_needs_rst_pwr", int'(!isolateM1 && !(domainRstN && pwrEn)), 0);
            check("inv_rst_needs_pwr", int'(domainRstN && !pwrEn), 0);
        end
    end

    task automatic wait_ack(input logic want, input int lim, input string name);
        int i = 0;
        while (pdAck !== want && i < lim) begin
            @(negedge ck);
            i++;
        end
        check(name, int'(pdAck), int'(want));
    endtask

    bit plant_on = 1'b0;
    bit stuck    = 1'b0;

    initial begin
        repeat (3) @(negedge ck);
        // Reset values.
        check("rst_pwrEn", int'(pwrEn), 0);
        check("rst_domainRstN", int'(domainRstN), 0);
        check("rst_isolateM1", int'(isolateM1), 1);
        check("rst_pdAck", int'(pdAck), 0);
        check("rst_pdErr", int'(pdErr), 0);
        arst = 1'b1;
        repeat (2) @(negedge ck);

        // Power-up, ack 3 cycles after pwrEn: rstN at k+14, ON at k+15.
        pdReq = 1'b1;
        @(negedge ck);                       // after edge k
        check("up_pwrEn", int'(pwrEn), 1);
        repeat (3) @(negedge ck);
        pwrAck = 1'b1;
        repeat (10) @(negedge ck);           // after k+13
        check("up_rst_still_low", int'(domainRstN), 0);
        @(negedge ck);                       // after k+14
        check("up_rst_high", int'(domainRstN), 1);
        check("up_iso_held", int'(isolateM1), 1);
        @(negedge ck);                       // after k+15
        check("up_iso_low", int'(isolateM1), 0);
        check("up_pdAck", int'(pdAck), 1);

        // Busy blocks power-down; then iso at k, rstN low at k+4, pwrEn low at k+5.
        pdReq  = 1'b0;
        busyM1 = 1'b1;
        repeat (10) @(negedge ck);
        check("busy_pdAck", int'(pdAck), 1);
        check("busy_iso", int'(isolateM1), 0);
        busyM1 = 1'b0;
        @(negedge ck);                       // after k
        check("dn_iso", int'(isolateM1), 1);
        check("dn_pdAck", int'(pdAck), 0);
        repeat (3) @(negedge ck);            // after k+3
        check("dn_rst_still_high", int'(domainRstN), 1);
        @(negedge ck);                       // after k+4
        check("dn_rst_low", int'(domainRstN), 0);
        check("dn_pwr_still_on", int'(pwrEn), 1);
        @(negedge ck);                       // after k+5
        check("dn_pwr_off", int'(pwrEn), 0);
        pwrAck = 1'b0;
        repeat (6) @(negedge ck);

        // Ack never arrives: timeout after 64 cycles in PWR_UP sets pdErr.
        pdReq = 1'b1;
        @(negedge ck);                       // after k
        repeat (63) @(negedge ck);           // after k+63
        check("to_err_not_yet", int'(pdErr), 0);
        @(negedge ck);                       // after k+64
        check("to_err_set", int'(pdErr), 1);
        errClr = 1'b1;
        @(negedge ck);
        errClr = 1'b0;
        check("to_err_cleared", int'(pdErr), 0);
        wait_ack(1'b1, 20, "to_reach_on");
        pdReq = 1'b0;
        repeat (12) @(negedge ck);
        check("to_back_off", int'(pwrEn), 0);

        // Request dropped during RST_REL: power-up completes, then powers down.
        pdReq = 1'b1;
        @(negedge ck);
        pwrAck = 1'b1;
        repeat (6) @(negedge ck);
        pdReq = 1'b0;
        wait_ack(1'b1, 30, "rr_reach_on");
        @(negedge ck);
        check("rr_auto_dn_pdAck", int'(pdAck), 0);
        check("rr_auto_dn_iso", int'(isolateM1), 1);
        repeat (6) @(negedge ck);
        pwrAck = 1'b0;
        repeat (6) @(negedge ck);

        // Asynchronous reset in ISO.
        pdReq = 1'b1;
        @(negedge ck);
        pwrAck = 1'b1;
        wait_ack(1'b1, 30, "ar_reach_on");
        pdReq = 1'b0;
        @(negedge ck);
        check("ar_in_iso", int'(isolateM1 && pwrEn && domainRstN), 1);
        #2 arst = 1'b0;
        #1;
        check("ar_iso", int'(isolateM1), 1);
        check("ar_rst", int'(domainRstN), 0);
        check("ar_pwr", int'(pwrEn), 0);
        check("ar_ack", int'(pdAck), 0);
        pwrAck = 1'b0;
        @(negedge ck);
        arst = 1'b1;
        repeat (4) @(negedge ck);
        check("ar_off_pwr", int'(pwrEn), 0);
        check("ar_off_iso", int'(isolateM1), 1);

        // Randomized run with a power-switch plant that follows pwrEn.
        plant_on = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge ck);
            if ($urandom_range(15) == 0) pdReq = ~pdReq;
            if ($urandom_range(3) == 0) busyM1 = ~busyM1;
            errClr = ($urandom_range(31) == 0);
            if ($urandom_range(199) == 0) stuck = ~stuck;
            if (!stuck && pwrAck != pwrEn && $urandom_range(3) == 0) pwrAck = pwrEn;
            if ($urandom_range(1499) == 0) begin
                #2 arst = 1'b0;
                @(negedge ck);
                arst = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
